// File: rtl/adj_map_arb_pkg.sv
// Shared types and constants for the two-requester adjacency-map arbiter.
package adj_map_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned NODE_W  = 10;

    typedef logic [NODE_W-1:0] node_t;

    typedef enum logic [1:0] {
        StIdle,
        StQuery,
        StReply
    } state_e;

endpackage

// File: rtl/adj_map_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// requester that did not complete the previous transaction.
module adj_map_rr_pick
    import adj_map_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               last_i,
    output logic               gnt_o
);

    always_comb begin
        gnt_o = 1'b0;
        case (req_i)
            2'b11:   gnt_o = ~last_i;
            2'b10:   gnt_o = 1'b1;
            default: gnt_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/adj_map_arbiter.sv
// Arbitrates two requesters onto one adjacency-map query/reply port; a
// transaction is one query handshake plus every reply beat up to the terminal one.
module adj_map_arbiter #(
    parameter int unsigned NODE_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [1:0]              req_query_valid,
    output logic [1:0]              req_query_ready,
    input  logic [2*NODE_WIDTH-1:0] req_query_data,
    output logic [1:0]              req_reply_valid,
    input  logic [1:0]              req_reply_ready,
    output logic [NODE_WIDTH-1:0]   req_reply_data,
    output logic                    req_reply_last,
    output logic                    req_reply_no_edges_found,

    output logic                    query_valid,
    input  logic                    query_ready,
    output logic [NODE_WIDTH-1:0]   query_data,
    input  logic                    reply_valid,
    output logic                    reply_ready,
    input  logic [NODE_WIDTH-1:0]   reply_data,
    input  logic                    reply_last,
    input  logic                    reply_no_edges_found,

    output logic                    grant_id,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    grant_cnt0,
    output logic [CNT_WIDTH-1:0]    grant_cnt1
);

    import adj_map_arb_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e               state_q, state_d;
    logic                 grant_q, grant_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
    logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
    logic                 pick;
    logic                 terminal;

    adj_map_rr_pick u_rr_pick (
        .req_i  (req_query_valid),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Reply payload is broadcast; only the valid/ready pair is steered.
    assign req_reply_data           = reply_data;
    assign req_reply_last           = reply_last;
    assign req_reply_no_edges_found = reply_no_edges_found;
    assign query_data = grant_q ? req_query_data[2*NODE_WIDTH-1:NODE_WIDTH]
                                : req_query_data[NODE_WIDTH-1:0];

    assign grant_id = grant_q;
    assign busy     = (state_q != StIdle);
    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

    assign terminal = reply_valid && reply_ready && (reply_last || reply_no_edges_found);

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_d          = last_q;
        cnt0_d          = cnt0_q;
        cnt1_d          = cnt1_q;
        query_valid     = 1'b0;
        req_query_ready = 2'b00;
        req_reply_valid = 2'b00;
        reply_ready     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|req_query_valid) begin
                    grant_d = pick;
                    state_d = StQuery;
                end
            end
            StQuery: begin
                // Granted requester may drop valid; we wait for it without re-arbitrating.
                query_valid              = req_query_valid[grant_q];
                req_query_ready[grant_q] = query_ready;
                if (query_valid && query_ready) begin
                    state_d = StReply;
                end
            end
            StReply: begin
                req_reply_valid[grant_q] = reply_valid;
                reply_ready              = req_reply_ready[grant_q];
                if (terminal) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                    if (!grant_q && (cnt0_q != CntMax)) begin
                        cnt0_d = cnt0_q + CNT_WIDTH'(1);
                    end
                    if (grant_q && (cnt1_q != CntMax)) begin
                        cnt1_d = cnt1_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

endmodule
